// File: rtl/gps_lut_pkg.sv
// Shared types and table geometry for the GPS interpolation LUT search controller.
package gps_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // cos table geometry
  localparam int unsigned COS_DEPTH   = 128;
  localparam int unsigned COS_ADDR_W  = 7;
  localparam int unsigned COS_KEY_W   = 48;
  localparam int unsigned COS_VAL_W   = 48;

  // asin table geometry
  localparam int unsigned ASIN_DEPTH  = 64;
  localparam int unsigned ASIN_ADDR_W = 6;
  localparam int unsigned ASIN_KEY_W  = 64;
  localparam int unsigned ASIN_VAL_W  = 64;

endpackage

// File: rtl/gps_lut_search_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer flips away from the winner on each grant.
module lut_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_c,
  output logic       any_c
);

  logic ptr_q, ptr_d;

  always_comb begin
    any_c = |req_i;
    gnt_c = 1'b0;
    ptr_d = ptr_q;
    case (req_i)
      2'b01:   gnt_c = 1'b0;
      2'b10:   gnt_c = 1'b1;
      2'b11:   gnt_c = ptr_q;
      default: gnt_c = 1'b0;
    endcase
    if (en_i && any_c) begin
      ptr_d = ~gnt_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gps_lut_search_ctrl.sv
// Arbitrates two requesters onto one interpolation ROM and linearly scans it for
// the entry pair bracketing the granted key.
module gps_lut_search_ctrl
  import gps_lut_pkg::*;
#(
  parameter int unsigned KEY_W  = 64,
  parameter int unsigned VAL_W  = 64,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               req,
  input  logic [KEY_W-1:0]         key0,
  input  logic [KEY_W-1:0]         key1,
  output logic [ADDR_W-1:0]        LUT_ADDR,
  input  logic [KEY_W+VAL_W-1:0]   LUT_DATA,
  output logic                     busy,
  output logic                     gnt_id,
  output logic                     done,
  output logic [KEY_W-1:0]         x0,
  output logic [KEY_W-1:0]         x1,
  output logic [VAL_W-1:0]         y0,
  output logic [VAL_W-1:0]         y1,
  output logic                     exact,
  output logic                     under,
  output logic                     over
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [KEY_W-1:0]   prev_x_q, prev_x_d;
  logic [VAL_W-1:0]   prev_y_q, prev_y_d;
  logic               busy_q, busy_d;
  logic               gnt_q, gnt_d;
  logic               done_q, done_d;
  logic [KEY_W-1:0]   x0_q, x0_d, x1_q, x1_d;
  logic [VAL_W-1:0]   y0_q, y0_d, y1_q, y1_d;
  logic               exact_q, exact_d, under_q, under_d, over_q, over_d;

  logic               arb_en_c;
  logic               arb_gnt_c;
  logic               arb_any_c;
  logic [KEY_W-1:0]   lut_x_c;
  logic [VAL_W-1:0]   lut_y_c;

  assign lut_x_c = LUT_DATA[KEY_W+VAL_W-1:VAL_W];
  assign lut_y_c = LUT_DATA[VAL_W-1:0];

  lut_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req),
    .en_i    (arb_en_c),
    .gnt_c   (arb_gnt_c),
    .any_c   (arb_any_c)
  );

  // Next-state, scan compare and result capture
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    key_d    = key_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    busy_d   = busy_q;
    gnt_d    = gnt_q;
    done_d   = 1'b0;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    exact_d  = exact_q;
    under_d  = under_q;
    over_d   = over_q;
    arb_en_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          arb_en_c = 1'b1;
          gnt_d    = arb_gnt_c;
          key_d    = arb_gnt_c ? key1 : key0;
          addr_d   = '0;
          exact_d  = 1'b0;
          under_d  = 1'b0;
          over_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (key_q == lut_x_c) begin
          x0_d    = lut_x_c;
          x1_d    = lut_x_c;
          y0_d    = lut_y_c;
          y1_d    = lut_y_c;
          exact_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (key_q < lut_x_c) begin
          x1_d    = lut_x_c;
          y1_d    = lut_y_c;
          // Below the first entry there is no lower neighbour, so clamp.
          if (addr_q == '0) begin
            x0_d    = lut_x_c;
            y0_d    = lut_y_c;
            under_d = 1'b1;
          end else begin
            x0_d    = prev_x_q;
            y0_d    = prev_y_q;
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          x0_d    = lut_x_c;
          x1_d    = lut_x_c;
          y0_d    = lut_y_c;
          y1_d    = lut_y_c;
          over_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          prev_x_d = lut_x_c;
          prev_y_d = lut_y_c;
          addr_d   = addr_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      key_q    <= '0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
      done_q   <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      exact_q  <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      key_q    <= key_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      exact_q  <= exact_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  assign LUT_ADDR = addr_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_q;
  assign done     = done_q;
  assign x0       = x0_q;
  assign x1       = x1_q;
  assign y0       = y0_q;
  assign y1       = y1_q;
  assign exact    = exact_q;
  assign under    = under_q;
  assign over     = over_q;

endmodule

// File: tb/tb_gps_lut_search_ctrl.sv
// Scoreboard bench for gps_lut_search_ctrl on an 8-entry table X_i = 16(i+1), Y_i = 1000-i.
module tb_gps_lut_search_ctrl;

  localparam int unsigned KW = 64;
  localparam int unsigned VW = 64;
  localparam int unsigned AW = 3;
  localparam int unsigned DP = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        req;
  logic [KW-1:0]     key0, key1;
  logic [AW-1:0]     lut_addr;
  logic [KW+VW-1:0]  lut_data;
  logic              busy, gnt_id, done, exact, under, over;
  logic [KW-1:0]     x0, x1;
  logic [VW-1:0]     y0, y1;

  always #5 clk = ~clk;

  always_comb lut_data = {KW'(16 * (int'(lut_addr) + 1)), VW'(1000 - int'(lut_addr))};

  gps_lut_search_ctrl #(.KEY_W(KW), .VAL_W(VW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .key0     (key0),
    .key1     (key1),
    .LUT_ADDR (lut_addr),
    .LUT_DATA (lut_data),
    .busy     (busy),
    .gnt_id   (gnt_id),
    .done     (done),
    .x0       (x0),
    .x1       (x1),
    .y0       (y0),
    .y1       (y1),
    .exact    (exact),
    .under    (under),
    .over     (over)
  );

  typedef struct {
    bit            id;
    logic [KW-1:0] x0, x1;
    logic [VW-1:0] y0, y1;
    bit            ex, un, ov;
    int            k;
    int            iss;
    bit            lat_chk;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   busy_run = 0;
  bit   fav = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference: first table entry whose X is not below the key decides the bracket.
  function automatic exp_t model(bit id, logic [KW-1:0] key);
    exp_t e;
    logic [KW-1:0] tx [DP];
    int i;
    for (int j = 0; j < DP; j++) tx[j] = KW'(16 * (j + 1));
    e.id = id; e.ex = 0; e.un = 0; e.ov = 0; e.iss = 0; e.lat_chk = 0;
    i = 0;
    while (i < DP && tx[i] < key) i++;
    if (i == DP) begin
      e.k = DP - 1; e.ov = 1;
      e.x0 = tx[DP-1]; e.x1 = tx[DP-1];
      e.y0 = VW'(1000 - (DP - 1)); e.y1 = e.y0;
    end else begin
      e.k = i;
      e.x1 = tx[i]; e.y1 = VW'(1000 - i);
      if (tx[i] == key) begin
        e.ex = 1; e.x0 = e.x1; e.y0 = e.y1;
      end else if (i == 0) begin
        e.un = 1; e.x0 = e.x1; e.y0 = e.y1;
      end else begin
        e.x0 = tx[i-1]; e.y0 = VW'(1000 - (i - 1));
      end
    end
    return e;
  endfunction

  function automatic logic [KW-1:0] rkey();
    case ($urandom_range(0, 3))
      0:       return KW'(16 * $urandom_range(1, 8));
      1:       return KW'($urandom_range(0, 140));
      2:       return {$urandom, $urandom};
      default: return KW'($urandom_range(0, 16));
    endcase
  endfunction

  // Monitor: compares each done against the oldest pending expectation.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_done: done seen with no pending request (t=%0t)", $time);
        end else begin
          cur = sb.pop_front();
          chk("gnt_id", 64'(gnt_id), 64'(cur.id));
          chk("x0", x0, cur.x0);
          chk("x1", x1, cur.x1);
          chk("y0", y0, cur.y0);
          chk("y1", y1, cur.y1);
          chk("exact", 64'(exact), 64'(cur.ex));
          chk("under", 64'(under), 64'(cur.un));
          chk("over", 64'(over), 64'(cur.ov));
          chk("busy_len", 64'(busy_run), 64'(cur.k + 2));
          if (cur.lat_chk) chk("latency", 64'(cyc - cur.iss), 64'(cur.k + 2));
        end
      end
      if (!busy) busy_run = 0;
    end
  end

  task automatic set_key(bit id, logic [KW-1:0] k);
    if (id) key1 = k; else key0 = k;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((req != 2'b00 || busy) && n < budget) begin
      @(negedge clk);
      if (done) req[gnt_id] = 1'b0;
      n++;
    end
    if (n >= budget) begin
      miscompares++;
      $display("FAIL wait_timeout: no completion within %0d cycles", budget);
    end
  endtask

  task automatic issue1(bit id, logic [KW-1:0] k);
    exp_t e;
    set_key(id, k);
    e = model(id, k);
    e.iss = cyc; e.lat_chk = 1;
    sb.push_back(e);
    fav = !id;
    req[id] = 1'b1;
    wait_idle(50);
  endtask

  // Both requesters kept busy; each re-raises one cycle after its own done.
  task automatic dual(int n);
    exp_t e;
    bit rr [2];
    bit id, last;
    int issued, guard;
    logic [KW-1:0] k;
    rr[0] = 0; rr[1] = 0;
    for (int s = 0; s < 2; s++) begin
      id = (s == 0) ? fav : !fav;
      k = rkey();
      set_key(id, k);
      e = model(id, k);
      sb.push_back(e);
    end
    last = !fav;
    req = 2'b11;
    issued = 2;
    guard = 0;
    while ((issued < n || req != 2'b00 || busy) && guard < n * 20) begin
      @(negedge clk);
      guard++;
      for (int j = 0; j < 2; j++) begin
        if (rr[j]) begin
          id = j[0];
          k = rkey();
          set_key(id, k);
          e = model(id, k);
          sb.push_back(e);
          req[id] = 1'b1;
          rr[j] = 0;
          issued++;
          last = id;
        end
      end
      if (done) begin
        req[gnt_id] = 1'b0;
        if (issued < n) rr[gnt_id] = 1;
      end
    end
    if (guard >= n * 20) begin
      miscompares++;
      $display("FAIL dual_timeout: dual-request phase did not finish");
    end
    fav = !last;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_gnt"}, 64'(gnt_id), 64'(0));
    chk({tag, "_addr"}, 64'(lut_addr), 64'(0));
    chk({tag, "_x0"}, x0, 64'(0));
    chk({tag, "_x1"}, x1, 64'(0));
    chk({tag, "_y0"}, y0, 64'(0));
    chk({tag, "_y1"}, y1, 64'(0));
    chk({tag, "_flags"}, 64'({exact, under, over}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset_n = 1'b0;
    req = 2'b00;
    key0 = '0;
    key1 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    issue1(1'b0, 64'd40);
    issue1(1'b1, 64'd64);
    issue1(1'b0, 64'd5);
    issue1(1'b0, 64'd500);
    issue1(1'b1, 64'd128);
    issue1(1'b0, 64'd16);

    // Key changed after grant must not affect the search.
    key0 = 64'd40;
    e = model(1'b0, 64'd40);
    e.iss = cyc; e.lat_chk = 1;
    sb.push_back(e);
    fav = 1'b1;
    req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    key0 = 64'd120;
    wait_idle(50);

    // Reset during the third scan cycle drops the request silently.
    key0 = 64'd500;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("scan3_busy", 64'(busy), 64'(1));
    chk("scan3_addr", 64'(lut_addr), 64'(2));
    reset_n = 1'b0;
    req = 2'b00;
    #1;
    check_reset_outputs("midscan");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    fav = 1'b0;
    @(negedge clk);
    dual(4);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) dual(int'($urandom_range(2, 5)));
      else issue1(1'($urandom_range(0, 1)), rkey());
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
